// File: rtl/traffic_light_monitor_if.sv
// Signal bundle between the traffic-light controller's lights bus and its passive monitor.
// The controller side (or bench) drives carew/lights; the monitor drives the check results.
interface traffic_light_monitor_if #(
  parameter int unsigned RW = 8
) ();
  logic          carew;
  logic [5:0]    lights;
  logic [2:0]    phase;
  logic          valid;
  logic          err;
  logic [1:0]    err_code;
  logic [RW-1:0] rounds;

  modport master (
    output carew, lights,
    input  phase, valid, err, err_code, rounds
  );

  modport slave (
    input  carew, lights,
    output phase, valid, err, err_code, rounds
  );
endinterface

// File: rtl/traffic_light_monitor.sv
// Passive checker for the traffic-light lights bus: decodes phases, checks transitions, counts rounds.
// Optional EW-starvation check is enabled by defining TLM_WAIT_CHECK_EN.
module traffic_light_monitor #(
  parameter int unsigned RW = 8
`ifdef TLM_WAIT_CHECK_EN
  ,
  parameter int unsigned WAIT_MAX = 6
`endif
) (
  input logic                    clk,
  input logic                    rst,
  traffic_light_monitor_if.slave mon
);

  typedef enum logic [2:0] {
    PhGns = 3'b000,
    PhYns = 3'b001,
    PhRns = 3'b010,
    PhGew = 3'b011,
    PhYew = 3'b100,
    PhRew = 3'b101,
    PhUnk = 3'b111
  } phase_e;

  typedef enum logic [0:0] {StUnsync, StTrack} state_e;

  localparam logic [1:0] ErrNone  = 2'b00;
  localparam logic [1:0] ErrEnc   = 2'b01;
  localparam logic [1:0] ErrTrans = 2'b10;
`ifdef TLM_WAIT_CHECK_EN
  localparam logic [1:0] ErrStarve = 2'b11;
  localparam int unsigned WW = $clog2(WAIT_MAX + 1);
`endif

  state_e        fsm_q, fsm_d;
  phase_e        phase_q, phase_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [RW-1:0] rounds_q, rounds_d;
  logic          carew_q, carew_d;
`ifdef TLM_WAIT_CHECK_EN
  logic [WW-1:0] wait_q, wait_d;
`endif

  phase_e     dec_ph;
  logic       dec_ok;
  logic       dec_red;
  phase_e     exp_ph;
  phase_e     new_ph;
  logic       err_hit;
  logic [1:0] err_kind;

  function automatic phase_e exp_next(phase_e p, logic c);
    case (p)
      PhGns:   return c ? PhYns : PhGns;
      PhYns:   return PhRns;
      PhRns:   return PhGew;
      PhGew:   return PhYew;
      PhYew:   return PhRew;
      PhRew:   return PhGns;
      default: return PhUnk;
    endcase
  endfunction

  always_comb begin
    dec_ph  = PhUnk;
    dec_ok  = 1'b1;
    dec_red = 1'b0;
    unique case (mon.lights)
      6'b100_001: dec_ph  = PhGns;
      6'b010_001: dec_ph  = PhYns;
      6'b001_100: dec_ph  = PhGew;
      6'b001_010: dec_ph  = PhYew;
      6'b001_001: dec_red = 1'b1;
      default:    dec_ok  = 1'b0;
    endcase
  end

  always_comb begin
    fsm_d      = fsm_q;
    phase_d    = phase_q;
    valid_d    = valid_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    rounds_d   = rounds_q;
    carew_d    = mon.carew;
    exp_ph     = exp_next(phase_q, carew_q);
    new_ph     = PhUnk;
    err_hit    = 1'b0;
    err_kind   = ErrNone;
`ifdef TLM_WAIT_CHECK_EN
    wait_d     = '0;
`endif

    unique case (fsm_q)
      StUnsync: begin
        if (dec_ok && !dec_red) begin
          fsm_d   = StTrack;
          phase_d = dec_ph;
          valid_d = 1'b1;
        end else begin
          phase_d = PhUnk;
          valid_d = 1'b0;
        end
      end
      StTrack: begin
        // RED resolves from history; outside YNS/YEW it stays PhUnk and fails the compare.
        if (dec_red) begin
          new_ph = (phase_q == PhYns) ? PhRns :
                   (phase_q == PhYew) ? PhRew : PhUnk;
        end else begin
          new_ph = dec_ph;
        end

        if (!dec_ok) begin
          err_hit  = 1'b1;
          err_kind = ErrEnc;
        end else if (new_ph != exp_ph) begin
          err_hit  = 1'b1;
          err_kind = ErrTrans;
        end

`ifdef TLM_WAIT_CHECK_EN
        if (!err_hit && mon.carew && (new_ph != PhGew)) begin
          wait_d = (wait_q == WW'(WAIT_MAX)) ? wait_q : wait_q + WW'(1);
          if (wait_d == WW'(WAIT_MAX)) begin
            err_hit  = 1'b1;
            err_kind = ErrStarve;
          end
        end
`endif

        if (!err_hit) begin
          phase_d = new_ph;
          if ((phase_q == PhRew) && (new_ph == PhGns)) begin
            rounds_d = rounds_q + RW'(1);
          end
        end
      end
      default: begin
        fsm_d   = StUnsync;
        phase_d = PhUnk;
        valid_d = 1'b0;
      end
    endcase

    if (err_hit) begin
      err_d   = 1'b1;
      fsm_d   = StUnsync;
      phase_d = PhUnk;
      valid_d = 1'b0;
      if (!err_q) begin
        err_code_d = err_kind;
      end
`ifdef TLM_WAIT_CHECK_EN
      wait_d = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm_q      <= StUnsync;
      phase_q    <= PhUnk;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ErrNone;
      rounds_q   <= '0;
      carew_q    <= 1'b0;
`ifdef TLM_WAIT_CHECK_EN
      wait_q     <= '0;
`endif
    end else begin
      fsm_q      <= fsm_d;
      phase_q    <= phase_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      rounds_q   <= rounds_d;
      carew_q    <= carew_d;
`ifdef TLM_WAIT_CHECK_EN
      wait_q     <= wait_d;
`endif
    end
  end

  assign mon.phase    = phase_q;
  assign mon.valid    = valid_q;
  assign mon.err      = err_q;
  assign mon.err_code = err_code_q;
  assign mon.rounds   = rounds_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Table-driven bench for traffic_light_monitor plus a rounds-wrap sequence and a mid-loop jump.
module tb_traffic_light_monitor;

  localparam logic [5:0] LGns = 6'b100_001;
  localparam logic [5:0] LYns = 6'b010_001;
  localparam logic [5:0] LRed = 6'b001_001;
  localparam logic [5:0] LGew = 6'b001_100;
  localparam logic [5:0] LYew = 6'b001_010;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  traffic_light_monitor_if #(.RW(8)) tif ();

  traffic_light_monitor #(.RW(8)) dut (
    .clk (clk),
    .rst (rst),
    .mon (tif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       carew;
    logic [5:0] lights;
    logic [2:0] phase;
    logic       valid;
    logic       err;
    logic [1:0] code;
    logic [7:0] rounds;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic c, input logic [5:0] l, input logic [2:0] ph,
                     input logic v, input logic e, input logic [1:0] cd, input logic [7:0] rn);
    vec_t t;
    t = '{rst: r, carew: c, lights: l, phase: ph, valid: v, err: e, code: cd, rounds: rn};
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
  endtask

  task automatic apply(input logic r, input logic c, input logic [5:0] l);
    rst       = r;
    tif.carew = c;
    tif.lights = l;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input int idx, input logic [2:0] ph, input logic v, input logic e,
                           input logic [1:0] cd, input logic [7:0] rn);
    check("phase", idx, 32'(tif.phase), 32'(ph));
    check("valid", idx, 32'(tif.valid), 32'(v));
    check("err", idx, 32'(tif.err), 32'(e));
    check("err_code", idx, 32'(tif.err_code), 32'(cd));
    check("rounds", idx, 32'(tif.rounds), 32'(rn));
  endtask

  initial begin
    n_pass     = 0;
    n_total    = 0;
    rst        = 1'b0;
    tif.carew  = 1'b0;
    tif.lights = LGns;

    // rst carew lights   phase  v  e  code   rounds
    add(0, 0, LGns,       3'h7,  0, 0, 2'b00, 8'd0);
    add(0, 0, LGns,       3'h7,  0, 0, 2'b00, 8'd0);
    add(1, 0, LRed,       3'h7,  0, 0, 2'b00, 8'd0);  // RED cannot lock
    add(1, 0, LRed,       3'h7,  0, 0, 2'b00, 8'd0);
    add(1, 0, LGns,       3'h0,  1, 0, 2'b00, 8'd0);
    add(1, 0, LGns,       3'h0,  1, 0, 2'b00, 8'd0);
    add(1, 1, LGns,       3'h0,  1, 0, 2'b00, 8'd0);
    add(1, 0, LYns,       3'h1,  1, 0, 2'b00, 8'd0);
    add(1, 0, LRed,       3'h2,  1, 0, 2'b00, 8'd0);
    add(1, 1, LGew,       3'h3,  1, 0, 2'b00, 8'd0);
    add(1, 0, LYew,       3'h4,  1, 0, 2'b00, 8'd0);
    add(1, 0, LRed,       3'h5,  1, 0, 2'b00, 8'd0);
    add(1, 0, LGns,       3'h0,  1, 0, 2'b00, 8'd1);
    add(1, 1, LGns,       3'h0,  1, 0, 2'b00, 8'd1);
    add(1, 0, LYns,       3'h1,  1, 0, 2'b00, 8'd1);
    add(1, 0, LRed,       3'h2,  1, 0, 2'b00, 8'd1);
    add(1, 0, LGew,       3'h3,  1, 0, 2'b00, 8'd1);
    add(1, 0, LYew,       3'h4,  1, 0, 2'b00, 8'd1);
    add(1, 0, LRed,       3'h5,  1, 0, 2'b00, 8'd1);
    add(1, 0, LGns,       3'h0,  1, 0, 2'b00, 8'd2);
    add(1, 0, LYns,       3'h7,  0, 1, 2'b10, 8'd2);  // YNS while carew was 0
    add(1, 0, LGns,       3'h0,  1, 1, 2'b10, 8'd2);
    add(1, 0, 6'b111111,  3'h7,  0, 1, 2'b10, 8'd2);  // first error code kept
    add(0, 0, LGns,       3'h7,  0, 0, 2'b00, 8'd0);
    add(1, 0, LGns,       3'h0,  1, 0, 2'b00, 8'd0);
    add(1, 0, 6'b110001,  3'h7,  0, 1, 2'b01, 8'd0);
    add(0, 0, 6'b110001,  3'h7,  0, 0, 2'b00, 8'd0);  // reset beats pending error
    add(1, 0, LGew,       3'h3,  1, 0, 2'b00, 8'd0);
    add(1, 0, LGew,       3'h7,  0, 1, 2'b10, 8'd0);
    add(0, 0, LGns,       3'h7,  0, 0, 2'b00, 8'd0);
    add(1, 0, LGns,       3'h0,  1, 0, 2'b00, 8'd0);
    add(1, 0, LRed,       3'h7,  0, 1, 2'b10, 8'd0);  // RED after GNS
    add(1, 0, 6'b000000,  3'h7,  0, 1, 2'b10, 8'd0);  // UNSYNC: no new error

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].carew, vecs[i].lights);
      check_all(i, vecs[i].phase, vecs[i].valid, vecs[i].err, vecs[i].code, vecs[i].rounds);
    end

    // Rounds wrap: 256 full loops from a clean reset.
    apply(0, 0, LGns);
    apply(1, 1, LGns);
    check_all(100, 3'h0, 1, 0, 2'b00, 8'd0);
    for (int k = 1; k <= 256; k++) begin
      apply(1, 0, LYns);
      apply(1, 0, LRed);
      apply(1, 0, LGew);
      apply(1, 0, LYew);
      apply(1, 0, LRed);
      check("rew_phase", 200 + k, 32'(tif.phase), 32'(3'h5));
      apply(1, 1, LGns);
      if (k == 255) check_all(101, 3'h0, 1, 0, 2'b00, 8'd255);
    end
    check_all(102, 3'h0, 1, 0, 2'b00, 8'd0);

    // Controller reset mid-sequence: GEW jumps straight to GNS.
    apply(1, 0, LYns);
    apply(1, 0, LRed);
    apply(1, 0, LGew);
    check_all(103, 3'h3, 1, 0, 2'b00, 8'd0);
    apply(1, 0, LGns);
    check_all(104, 3'h7, 0, 1, 2'b10, 8'd0);

    // Same jump with the monitor reset in the same cycle: no error.
    apply(1, 0, LGns);
    apply(0, 0, LGns);
    apply(1, 1, LGns);
    apply(1, 0, LYns);
    apply(1, 0, LRed);
    apply(1, 0, LGew);
    apply(0, 0, LGns);
    check_all(105, 3'h7, 0, 0, 2'b00, 8'd0);
    apply(1, 0, LGns);
    check_all(106, 3'h0, 1, 0, 2'b00, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
